regfile_write_arbiter: RTL and testbench

Shares the single write port (`enc`/`addrc`/`datac`) of the 32×32 `Registers` file between `NREQ` requesters. Uses round-robin arbitration with a req/gnt handshake and registers the winning write onto the register-file port. Passes the two register-file read ports through, with optional forwarding of the pending write. Sits between the execute/load/CSR write-back sources and `Registers`.

---
 rtl/regarb_pkg.sv | 50 +++++
 rtl/rr_arbiter.sv | 53 +++++
 rtl/regfile_write_arbiter.sv | 123 ++++++++++++
 tb/tb_regfile_write_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regarb_pkg.sv
// ---------------------------------------------------------------------------
// regarb_pkg
// Shared constants and the round-robin pick function used by the register
// file write arbiter (regfile_write_arbiter) and its rr_arbiter sub-block.
//   REGARB_NREQ / REGARB_AW / REGARB_DW : default requester count, address
//                                         width and data width.
//   rr_pick(req, ptr, nreq)             : one-hot grant of the first asserted
//                                         request at or after ptr, scanning
//                                         upward modulo nreq.
// ---------------------------------------------------------------------------
package regarb_pkg;

    localparam int REGARB_NREQ = 4;
    localparam int REGARB_AW   = 5;
    localparam int REGARB_DW   = 32;

    // The pick function works on a fixed maximum width so a single function
    // serves every legal NREQ (2..8); unused upper bits are simply zero.
    localparam int REGARB_MAXREQ = 8;
    localparam int REGARB_PTRW   = 3;

    typedef logic [REGARB_MAXREQ-1:0] regarb_req_t;
    typedef logic [REGARB_PTRW-1:0]   regarb_ptr_t;
    // One extra bit so ptr + offset never wraps before the modulo step.
    typedef logic [REGARB_PTRW:0]     regarb_cnt_t;

    function automatic regarb_req_t rr_pick(
        input regarb_req_t req,
        input regarb_ptr_t ptr,
        input regarb_cnt_t nreq
    );
        regarb_req_t gnt;
        logic        found;
        regarb_cnt_t sum;
        regarb_cnt_t idx;
        gnt   = '0;
        found = 1'b0;
        for (int k = 0; k < REGARB_MAXREQ; k++) begin
            sum = {1'b0, ptr} + regarb_cnt_t'(k);
            // ptr < nreq and k < nreq, so one subtraction is a full modulo.
            idx = (sum >= nreq) ? (sum - nreq) : sum;
            if ((regarb_cnt_t'(k) < nreq) && !found && req[idx[REGARB_PTRW-1:0]]) begin
                gnt[idx[REGARB_PTRW-1:0]] = 1'b1;
                found                     = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter owning the rotation pointer. The grant is purely
// combinational; the pointer advances past the winner on every accept.
// Ports:
//   clk_i   : clock, rising edge
//   srst_i  : synchronous active-high reset (pointer -> 0)
//   en_i    : grant enable; when low no grant is issued and pointer holds
//   req_i   : per-requester write pending
//   gnt_o   : one-hot grant, same cycle as the accept edge
// ---------------------------------------------------------------------------
module rr_arbiter
    import regarb_pkg::*;
#(
    parameter int NREQ = REGARB_NREQ
) (
    input  logic            clk_i,
    input  logic            srst_i,
    input  logic            en_i,
    input  logic [NREQ-1:0] req_i,
    output logic [NREQ-1:0] gnt_o
);

    localparam int PW = $clog2(NREQ);

    logic [PW-1:0] rr_ptr_q;
    logic [PW-1:0] rr_ptr_d;
    regarb_req_t   pick;

    always_comb begin
        pick  = rr_pick(regarb_req_t'(req_i), regarb_ptr_t'(rr_ptr_q), regarb_cnt_t'(NREQ));
        gnt_o = en_i ? pick[NREQ-1:0] : '0;
    end

    // Next pointer is one past the winner; no grant leaves it unchanged.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_o[i]) begin
                rr_ptr_d = (i == NREQ - 1) ? '0 : PW'(i + 1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
// Shares the single write port of the register file between NREQ
// requesters with round-robin req/gnt arbitration, registers the winning
// write onto enc/addrc/datac, and passes both read ports through.
// Optional feature macro: REGARB_BYPASS_EN -- when defined, a registered but
// not yet committed write is forwarded to same-cycle reads of its address.
// Ports:
//   clock, reset          : clock (rising edge), synchronous active-high reset
//   wr_req/wr_addr/wr_data: packed per-requester request, address, data
//   wr_gnt                : one-hot combinational grant
//   stall                 : register file unavailable, suppresses grants
//   enc/addrc/datac       : registered write port to the register file
//   addra/addrb           : consumer read addresses
//   rf_addra/rf_addrb     : read addresses to the register file
//   rf_dataa/rf_datab     : read data from the register file
//   dataa/datab           : read data to the consumer
// ---------------------------------------------------------------------------
module regfile_write_arbiter
    import regarb_pkg::*;
#(
    parameter int NREQ = REGARB_NREQ,
    parameter int AW   = REGARB_AW,
    parameter int DW   = REGARB_DW
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NREQ-1:0]   wr_req,
    input  logic [NREQ*AW-1:0] wr_addr,
    input  logic [NREQ*DW-1:0] wr_data,
    output logic [NREQ-1:0]   wr_gnt,
    input  logic              stall,
    output logic              enc,
    output logic [AW-1:0]     addrc,
    output logic [DW-1:0]     datac,
    input  logic [AW-1:0]     addra,
    input  logic [AW-1:0]     addrb,
    output logic [AW-1:0]     rf_addra,
    output logic [AW-1:0]     rf_addrb,
    input  logic [DW-1:0]     rf_dataa,
    input  logic [DW-1:0]     rf_datab,
    output logic [DW-1:0]     dataa,
    output logic [DW-1:0]     datab
);

    logic          grant_en;
    logic          accept;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;
    logic [AW-1:0] addr_mask [NREQ];
    logic [DW-1:0] data_mask [NREQ];

    logic          enc_q,   enc_d;
    logic [AW-1:0] addrc_q, addrc_d;
    logic [DW-1:0] datac_q, datac_d;

    // Reset is folded in so no grant is ever visible during a reset cycle.
    assign grant_en = !stall && !reset;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr_arbiter (
        .clk_i  (clock),
        .srst_i (reset),
        .en_i   (grant_en),
        .req_i  (wr_req),
        .gnt_o  (wr_gnt)
    );

    // Grant is one-hot, so AND-masking and OR-reducing selects the winner.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_sel
            assign addr_mask[gi] = wr_addr[gi*AW +: AW] & {AW{wr_gnt[gi]}};
            assign data_mask[gi] = wr_data[gi*DW +: DW] & {DW{wr_gnt[gi]}};
        end
    endgenerate

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            sel_addr = sel_addr | addr_mask[i];
            sel_data = sel_data | data_mask[i];
        end
    end

    assign accept = |wr_gnt;

    // Address/data hold when nothing is accepted; only enc drops.
    always_comb begin
        enc_d   = accept;
        addrc_d = accept ? sel_addr : addrc_q;
        datac_d = accept ? sel_data : datac_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            enc_q   <= 1'b0;
            addrc_q <= '0;
            datac_q <= '0;
        end else begin
            enc_q   <= enc_d;
            addrc_q <= addrc_d;
            datac_q <= datac_d;
        end
    end

    assign enc   = enc_q;
    assign addrc = addrc_q;
    assign datac = datac_q;

    assign rf_addra = addra;
    assign rf_addrb = addrb;

`ifdef REGARB_BYPASS_EN
    assign dataa = (enc_q && (addrc_q == addra)) ? datac_q : rf_dataa;
    assign datab = (enc_q && (addrc_q == addrb)) ? datac_q : rf_datab;
`else
    assign dataa = rf_dataa;
    assign datab = rf_datab;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_write_arbiter
// Self-checking bench for regfile_write_arbiter with a behavioural 32x32
// register file attached to the write and read ports. Expected writes are
// queued when a grant is predicted and popped when enc is observed.
// Honours REGARB_BYPASS_EN for the forwarding expectations.
// ---------------------------------------------------------------------------
module tb_regfile_write_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic               clock;
    logic               reset;
    logic [NREQ-1:0]    wr_req;
    logic [NREQ*AW-1:0] wr_addr;
    logic [NREQ*DW-1:0] wr_data;
    logic [NREQ-1:0]    wr_gnt;
    logic               stall;
    logic               enc;
    logic [AW-1:0]      addrc;
    logic [DW-1:0]      datac;
    logic [AW-1:0]      addra, addrb;
    logic [AW-1:0]      rf_addra, rf_addrb;
    logic [DW-1:0]      rf_dataa, rf_datab;
    logic [DW-1:0]      dataa, datab;

    logic [AW-1:0] ra [NREQ];
    logic [DW-1:0] rd [NREQ];

    logic [DW-1:0] rf_mem [32];
    logic          rf_clr;

    int            n_checks;
    int            n_fail;
    int            m_ptr;
    int            cyc;
    logic [NREQ-1:0] obs_gnt;
    logic [NREQ-1:0] seen;
    logic [AW+DW-1:0] sb_q [$];
    logic [DW-1:0] exp_fwd;

    regfile_write_arbiter #(
        .NREQ (NREQ),
        .AW   (AW),
        .DW   (DW)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .wr_req   (wr_req),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_gnt   (wr_gnt),
        .stall    (stall),
        .enc      (enc),
        .addrc    (addrc),
        .datac    (datac),
        .addra    (addra),
        .addrb    (addrb),
        .rf_addra (rf_addra),
        .rf_addrb (rf_addrb),
        .rf_dataa (rf_dataa),
        .rf_datab (rf_datab),
        .dataa    (dataa),
        .datab    (datab)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            wr_addr[i*AW +: AW] = ra[i];
            wr_data[i*DW +: DW] = rd[i];
        end
    end

    // Behavioural register file: writes on the edge after enc is presented.
    always @(posedge clock) begin
        if (rf_clr) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= '0;
        end else if (enc) begin
            rf_mem[addrc] <= datac;
        end
    end
    assign rf_dataa = rf_mem[rf_addra];
    assign rf_datab = rf_mem[rf_addrb];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_pick(input logic [NREQ-1:0] req, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (ptr + k) % NREQ;
            if (req[idx]) return idx;
        end
        return -1;
    endfunction

    // Inputs are already driven; check the grant, predict, cross one edge,
    // then check the registered write port against the scoreboard.
    task automatic step();
        int               w;
        logic             exp_enc;
        logic [AW+DW-1:0] exp_wr;
        #1;
        w = (reset || stall) ? -1 : model_pick(wr_req, m_ptr);
        obs_gnt = wr_gnt;
        check_val("wr_gnt", {60'd0, wr_gnt}, (w < 0) ? 64'd0 : (64'd1 << w));
        exp_enc = (w >= 0);
        if (w >= 0) begin
            sb_q.push_back({ra[w], rd[w]});
            m_ptr = (w + 1) % NREQ;
        end
        if (reset) m_ptr = 0;
        @(posedge clock);
        #1;
        cyc++;
        check_val("enc", {63'd0, enc}, {63'd0, exp_enc});
        if (exp_enc) begin
            exp_wr = sb_q.pop_front();
            check_val("write", {27'd0, addrc, datac}, {27'd0, exp_wr});
            $display("cycle %0d: write req%0d addr=%0d data=%0d enc=%0b", cyc, w, addrc, datac, enc);
        end else begin
            $display("cycle %0d: no write reset=%0b stall=%0b enc=%0b", cyc, reset, stall, enc);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_ptr    = 0;
        cyc      = 0;
        rf_clr   = 1'b1;
        reset    = 1'b1;
        stall    = 1'b0;
        wr_req   = '1;
        addra    = '0;
        addrb    = '0;
        for (int i = 0; i < NREQ; i++) begin
            ra[i] = AW'(i + 1);
            rd[i] = DW'(100 + i);
        end

        // Reset held 3 cycles with every requester asserted.
        repeat (3) step();
        check_val("rst_addrc", {59'd0, addrc}, 64'd0);
        check_val("rst_datac", {32'd0, datac}, 64'd0);
        rf_clr = 1'b0;
        reset  = 1'b0;

        // Requesters 0 and 2 to address 31: grants alternate 0,2,0,2.
        ra[0] = 5'd31; rd[0] = 32'd3098;
        ra[2] = 5'd31; rd[2] = 32'd9912;
        wr_req = 4'b0101;
        step();
        check_val("first_gnt", {60'd0, obs_gnt}, 64'h1);
        repeat (3) step();
        wr_req = '0;
        addra  = 5'd31;
        step();
        check_val("rf_addra", {59'd0, rf_addra}, 64'd31);
        check_val("readback31", {32'd0, dataa}, 64'd9912);

        // All four held after a fresh reset: 0,1,2,3 then 0 again.
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            ra[i] = AW'(10 + i);
            rd[i] = DW'(1000 + i);
        end
        wr_req = '1;
        seen   = '0;
        repeat (4) begin
            step();
            seen = seen | obs_gnt;
        end
        check_val("all_granted", {60'd0, seen}, 64'hF);
        step();
        check_val("wrap_gnt", {60'd0, obs_gnt}, 64'h1);

        // Stall for 5 cycles with req1 pending, then release.
        wr_req = 4'b0010;
        stall  = 1'b1;
        repeat (5) step();
        stall = 1'b0;
        step();
        check_val("post_stall_gnt", {60'd0, obs_gnt}, 64'h2);
        wr_req = '0;

        // Forwarding: seed address 5 with 1234, then write 9912.
        ra[3]  = 5'd5;
        rd[3]  = 32'd1234;
        wr_req = 4'b1000;
        step();
        wr_req = '0;
        step();
        rd[3]  = 32'd9912;
        wr_req = 4'b1000;
        addra  = 5'd5;
        addrb  = 5'd5;
        step();
`ifdef REGARB_BYPASS_EN
        exp_fwd = 32'd9912;
`else
        exp_fwd = 32'd1234;
`endif
        check_val("dataa_cycN", {32'd0, dataa}, {32'd0, exp_fwd});
        check_val("datab_cycN", {32'd0, datab}, {32'd0, exp_fwd});
        check_val("rf_addrb", {59'd0, rf_addrb}, 64'd5);
        wr_req = '0;
        step();
        check_val("dataa_cycN1", {32'd0, dataa}, 64'd9912);

        // Reset the cycle after a grant: the accepted write lands, later ones do not.
        ra[0]  = 5'd7;
        rd[0]  = 32'hAAAA;
        wr_req = 4'b0001;
        step();
        rd[0]  = 32'hBBBB;
        reset  = 1'b1;
        step();
        step();
        reset  = 1'b0;
        wr_req = '0;
        addra  = 5'd7;
        step();
        check_val("mid_rst_addrc", {59'd0, addrc}, 64'd0);
        check_val("mid_rst_datac", {32'd0, datac}, 64'd0);
        check_val("mid_rst_reg7", {32'd0, dataa}, 64'hAAAA);

        check_val("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
